// File: rtl/mem_instr_sequencer.sv
// rtl/mem_instr_sequencer.sv - multi-cycle control FSM for ld/ldi/st with memory wait states,
// access timeout, illegal-opcode trap and back-to-back issue.
module mem_instr_sequencer #(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   OPC_MSB    = 31,
  parameter int                   OPC_W      = 5,
  parameter int                   ALU_OP_W   = 5,
  parameter logic [ALU_OP_W-1:0]  ALU_ADD    = ALU_OP_W'(2),
  parameter logic [OPC_W-1:0]     OP_LD      = OPC_W'(0),
  parameter logic [OPC_W-1:0]     OP_LDI     = OPC_W'(1),
  parameter logic [OPC_W-1:0]     OP_ST      = OPC_W'(2),
  parameter int                   MAX_WAIT   = 15
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] ir,
  input  logic                  mem_ready,
  output logic                  PCout,
  output logic                  Zlowout,
  output logic                  MDRout,
  output logic                  Cout,
  output logic                  BAout,
  output logic                  Rout,
  output logic                  MARin,
  output logic                  Zlowin,
  output logic                  PCin,
  output logic                  MDRin,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  Rin,
  output logic                  IncPC,
  output logic                  Read,
  output logic                  Write,
  output logic                  Gra,
  output logic                  Grb,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal_op,
  output logic                  mem_timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4,
    S_LD5, S_LD6, S_LD7, S_LDI5,
    S_ST5, S_ST6, S_ST7, S_ERR, S_TOUT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [OPC_W-1:0]   op_q, op_d;
  logic               access_st;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      op_q       <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      op_q       <= op_d;
    end
  end

  assign access_st = (state_q == S_T1) || (state_q == S_LD6) || (state_q == S_ST7);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    op_d       = op_q;
    if (access_st && !mem_ready) begin
      // Hold the access; the cycle that finds the counter saturated traps instead.
      if (wait_cnt_q == CNT_W'(MAX_WAIT)) state_d = S_TOUT;
      else wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end else begin
      unique case (state_q)
        S_IDLE: if (start) state_d = S_T0;
        S_T0:   state_d = S_T1;
        S_T1:   state_d = S_T2;
        S_T2:   state_d = S_T3;
        S_T3: begin
          state_d = S_T4;
          op_d    = ir[OPC_MSB -: OPC_W];
        end
        S_T4: begin
          if (op_q == OP_LD)       state_d = S_LD5;
          else if (op_q == OP_LDI) state_d = S_LDI5;
          else if (op_q == OP_ST)  state_d = S_ST5;
          else                     state_d = S_ERR;
        end
        S_LD5:  state_d = S_LD6;
        S_LD6:  state_d = S_LD7;
        S_ST5:  state_d = S_ST6;
        S_ST6:  state_d = S_ST7;
        S_LD7, S_LDI5, S_ST7: state_d = start ? S_T0 : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0; BAout = 1'b0; Rout = 1'b0;
    MARin = 1'b0; Zlowin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; Rin = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0; Gra = 1'b0; Grb = 1'b0;
    alu_op = '0;
    done = 1'b0; illegal_op = 1'b0; mem_timeout = 1'b0;
    busy = (state_q != S_IDLE);
    unique case (state_q)
      S_T0:   begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
      S_T1:   begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2:   begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3:   begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
      S_T4:   begin Cout = 1'b1; Zlowin = 1'b1; alu_op = ALU_ADD; end
      S_LD5:  begin Zlowout = 1'b1; MARin = 1'b1; end
      S_LD6:  begin Read = 1'b1; MDRin = 1'b1; end
      S_LD7:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
      S_LDI5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
      S_ST5:  begin Zlowout = 1'b1; MARin = 1'b1; end
      S_ST6:  begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
      S_ST7:  begin Write = 1'b1; done = mem_ready; end
      S_ERR:  illegal_op = 1'b1;
      S_TOUT: mem_timeout = 1'b1;
      default: ;
    endcase
  end

endmodule
